vram_arbiter: RTL and testbench



---
 rtl/vram_arbiter.sv | 123 ++++++++++++
 tb/tb_vram_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Character-RAM arbiter: display fetch has absolute priority, free slots shared
// round-robin between an external writer and a screen-clear engine.
module vram_arbiter #(
  parameter int DW    = 8,
  parameter int AW    = 12,
  parameter int COLS  = 80,
  parameter int ROWS  = 30,
  parameter int DEPTH = COLS * ROWS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_tick,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          vblank_only,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_data,
  output logic          clr_busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid
);

  // state | meaning
  // IDLE  | no fill in progress
  // CLEAR | fill engine competing for free slots, writing clr_q at clr_cnt
  typedef enum logic {IDLE, CLEAR} clr_state_t;

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  clr_state_t    state;
  logic [AW-1:0] clr_cnt;
  logic [DW-1:0] clr_q;
  logic          clr_fin;
  logic          last;
  logic          fetch1, fetch2;

  logic          disp_slot, blocked, wr_cand, clr_cand, grant_wr, grant_clr;
  logic [4:0]    row;
  logic [AW-1:0] disp_addr;

  always_comb begin
    disp_slot = p_tick && (pixel_x < 10'd640) && (pixel_y < 10'd480);
    blocked   = vblank_only && (pixel_y < 10'd480);
    wr_cand   = wr_req && !wr_ack && !blocked;
    clr_cand  = (state == CLEAR) && !blocked;
    // last=1 means the clear engine won most recently, so the writer goes next
    grant_wr  = !disp_slot && wr_cand && (!clr_cand || last);
    grant_clr = !disp_slot && clr_cand && !grant_wr;
    row       = pixel_y[8:4];
    disp_addr = AW'({row, 6'b0}) + AW'({row, 4'b0}) + AW'(pixel_x[9:3]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      clr_q      <= '0;
      clr_fin    <= 1'b0;
      clr_busy   <= 1'b0;
      last       <= 1'b0;
      fetch1     <= 1'b0;
      fetch2     <= 1'b0;
      wr_ack     <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else begin
      wr_ack     <= 1'b0;
      mem_we     <= 1'b0;
      fetch1     <= disp_slot;
      fetch2     <= fetch1;
      disp_valid <= fetch2;
      if (fetch2) disp_data <= mem_rdata;

      // busy drops one cycle after the final fill write reaches the RAM
      if (clr_fin) begin
        clr_fin  <= 1'b0;
        clr_busy <= 1'b0;
      end

      if (state == IDLE && clr_start) begin
        clr_q    <= clr_data;
        clr_cnt  <= '0;
        state    <= CLEAR;
        clr_busy <= 1'b1;
        clr_fin  <= 1'b0;
      end

      if (disp_slot) begin
        mem_addr <= disp_addr;
      end else if (grant_wr) begin
        wr_ack <= 1'b1;
        last   <= 1'b0;
        if (wr_addr < DEPTH_A) begin
          mem_addr  <= wr_addr;
          mem_we    <= 1'b1;
          mem_wdata <= wr_data;
        end
      end else if (grant_clr) begin
        mem_addr  <= clr_cnt;
        mem_we    <= 1'b1;
        mem_wdata <= clr_q;
        last      <= 1'b1;
        clr_cnt   <= clr_cnt + 1'b1;
        if (clr_cnt == DEPTH_A - 1'b1) begin
          state   <= IDLE;
          clr_fin <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a synchronous RAM model behind it.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset, p_tick, wr_req, vblank_only, clr_start;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] wr_addr, mem_addr;
  logic [7:0]  wr_data, clr_data, mem_wdata, mem_rdata, disp_data;
  logic        wr_ack, clr_busy, mem_we, disp_valid;

  logic [7:0]  ram [0:4095];
  int          checks = 0;
  int          errors = 0;

  vram_arbiter dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .vblank_only(vblank_only), .clr_start(clr_start), .clr_data(clr_data),
    .clr_busy(clr_busy), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .disp_data(disp_data), .disp_valid(disp_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int acks, nw, bad, last_we, done_cyc, writes;
    ram[162] = 8'h5A;
    reset = 1'b1; p_tick = 1'b0; pixel_x = '0; pixel_y = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; vblank_only = 1'b0;
    clr_start = 1'b0; clr_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_wr_ack", 32'(wr_ack), 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_disp", 32'({disp_valid, disp_data}), 0);

    // display fetch at x=17, y=35 -> row 2, col 2 -> 162
    p_tick = 1'b1; pixel_x = 10'd17; pixel_y = 10'd35;
    tick();
    chk("disp_addr", 32'(mem_addr), 162);
    chk("disp_we", 32'(mem_we), 0);
    chk("disp_valid_n1", 32'(disp_valid), 0);
    p_tick = 1'b0;
    tick();
    chk("disp_valid_n2", 32'(disp_valid), 0);
    tick();
    chk("disp_valid_n3", 32'(disp_valid), 1);
    chk("disp_data", 32'(disp_data), 32'h5A);
    tick();
    chk("disp_valid_drop", 32'(disp_valid), 0);

    // writer in active area: waits for the p_tick=0 slot
    pixel_y = 10'd100; p_tick = 1'b1;
    wr_req = 1'b1; wr_addr = 12'd5; wr_data = 8'h41;
    tick();
    chk("wr_blocked_ack", 32'(wr_ack), 0);
    chk("wr_blocked_we", 32'(mem_we), 0);
    p_tick = 1'b0;
    tick();
    chk("wr_ack", 32'(wr_ack), 1);
    chk("wr_write", 32'({mem_we, mem_addr, mem_wdata}), {1'b1, 12'd5, 8'h41});
    tick();
    chk("wr_no_double_ack", 32'(wr_ack), 0);
    chk("wr_no_double_we", 32'(mem_we), 0);
    wr_req = 1'b0;
    tick();
    chk("wr_ram5", 32'(ram[5]), 32'h41);

    // vblank_only holds the writer off until y reaches 480
    vblank_only = 1'b1; pixel_y = 10'd200;
    wr_req = 1'b1; wr_addr = 12'd7; wr_data = 8'h33;
    acks = 0;
    repeat (4) begin
      tick();
      if (wr_ack) acks++;
    end
    chk("vb_no_ack", 32'(acks), 0);
    pixel_y = 10'd480;
    tick();
    chk("vb_ack", 32'(wr_ack), 1);
    chk("vb_write", 32'({mem_we, mem_addr}), {1'b1, 12'd7});
    wr_req = 1'b0; vblank_only = 1'b0;
    tick();

    // full clear in blanking; a second start mid-fill must be ignored
    pixel_y = 10'd500; clr_data = 8'h20; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("clr_busy_set", 32'(clr_busy), 1);
    nw = 0; bad = 0; last_we = -1; done_cyc = -1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      tick();
      if (mem_we) begin
        if (mem_addr !== nw[11:0] || mem_wdata !== 8'h20) bad++;
        nw++;
        last_we = cyc;
      end
      if (!clr_busy) begin
        done_cyc = cyc;
        break;
      end
      clr_start = (cyc == 100);
      clr_data  = (cyc == 100) ? 8'h55 : 8'h20;
    end
    clr_start = 1'b0;
    chk("clr_write_count", 32'(nw), 2400);
    chk("clr_addr_data_errs", 32'(bad), 0);
    chk("clr_busy_fall", 32'(done_cyc), 32'(last_we + 1));
    chk("clr_ram_2399", 32'(ram[2399]), 32'h20);

    // clear and writer contending in blanking: grants alternate
    clr_data = 8'h00; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wr_req = 1'b1; wr_addr = 12'd10; wr_data = 8'h77;
    tick();
    chk("ct1_ack", 32'(wr_ack), 1);
    chk("ct1_addr", 32'(mem_addr), 10);
    tick();
    chk("ct2_ack", 32'(wr_ack), 0);
    chk("ct2_clr", 32'({mem_we, mem_addr, mem_wdata}), {1'b1, 12'd0, 8'h00});
    tick();
    chk("ct3_ack", 32'(wr_ack), 1);
    chk("ct3_addr", 32'(mem_addr), 10);
    tick();
    chk("ct4_ack", 32'(wr_ack), 0);
    chk("ct4_addr", 32'(mem_addr), 1);
    wr_addr = 12'd2500;
    tick();
    chk("oor_ack", 32'(wr_ack), 1);
    chk("oor_we", 32'(mem_we), 0);
    chk("oor_addr_hold", 32'(mem_addr), 1);
    wr_req = 1'b0;

    // reset mid-fill aborts immediately
    repeat (1000) tick();
    chk("mid_busy", 32'(clr_busy), 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(clr_busy), 0);
    chk("abort_we", 32'(mem_we), 0);
    repeat (2) tick();
    reset = 1'b0;
    writes = 0;
    repeat (6) begin
      tick();
      if (mem_we) writes++;
    end
    chk("abort_no_writes", 32'(writes), 0);
    chk("abort_busy_after", 32'(clr_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
